// File: rtl/xrv_mult_pkg.sv
// ---------------------------------------------------------------------------
// xrv_mult_pkg
// Shared types and helpers for the sequential RV M-extension multiplier.
//   mult_type_e : decoded multiply operation (low two bits of mult_type)
//   state_e     : control FSM states of xrv_mult_seq
//   pair_count  : number of PWxPW digit products needed for an operation
// ---------------------------------------------------------------------------
package xrv_mult_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // MUL only needs the digit pairs that land in the low word (i+j < n),
    // the high-word ops need the full n x n square.
    function automatic int unsigned pair_count(input int unsigned n, input logic is_mul);
        return is_mul ? (n * (n + 1)) / 2 : n * n;
    endfunction

endpackage

// File: rtl/xrv_mult_dsp.sv
// ---------------------------------------------------------------------------
// xrv_mult_dsp
// Combinational PW x PW unsigned multiplier. Isolated so a vendor DSP
// primitive can be dropped in without touching the sequencing logic.
//   x, y : PW-bit unsigned digits
//   p    : 2*PW-bit unsigned product
// ---------------------------------------------------------------------------
module xrv_mult_dsp #(
    parameter int PW = 16
) (
    input  logic [PW-1:0]   x,
    input  logic [PW-1:0]   y,
    output logic [2*PW-1:0] p
);

    assign p = {{PW{1'b0}}, x} * {{PW{1'b0}}, y};

endmodule

// File: rtl/xrv_mult_seq.sv
// ---------------------------------------------------------------------------
// xrv_mult_seq
// Sequential multiplier for RV32/RV64 MUL, MULH, MULHSU and MULHU. One
// PWxPW digit product per cycle is accumulated into a 2*XLEN register; a
// one-entry operand cache lets a MUL that follows a matching MULH* finish
// in a single cycle.
//   clk, rstb      : clock, asynchronous active-low reset
//   a, b           : rs1 / rs2 operands
//   mult_type      : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (bit 2 ignored)
//   valid / ready  : request handshake, accepted when valid & ready & ~flush
//   flush          : kills the current op and invalidates the cache
//   result         : product word, held until the next result_valid
//   result_valid   : one-cycle pulse when result is new
// ---------------------------------------------------------------------------
module xrv_mult_seq
    import xrv_mult_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PW       = 16,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      mult_type,
    input  logic            valid,
    input  logic            flush,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int N      = XLEN / PW;
    localparam int ACCW   = 2 * XLEN;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int P_MUL  = int'(pair_count(N, 1'b1));
    localparam int P_FULL = int'(pair_count(N, 1'b0));
    localparam int CW     = $clog2(P_FULL + 1);

    state_e          state, next_state;
    mult_type_e      req_mode, cur_mode, key_mode;
    logic            accept, hit, cache_avail;
    logic            req_a_sign, req_b_sign;
    logic [XLEN-1:0] req_mag_a, req_mag_b;
    logic [XLEN-1:0] op_a, op_b, key_a, key_b;
    logic            neg_q, is_hit_q, cache_valid;
    logic [IW-1:0]   dig_i, dig_j;
    logic [CW-1:0]   pair_cnt;
    logic            last_pair, end_of_row;
    logic [ACCW-1:0] acc, acc_fin, pp_shifted;
    logic [XLEN-1:0] a_shift, b_shift, fin_word, result_q;
    logic [PW-1:0]   a_dig, b_dig;
    logic [2*PW-1:0] pp;
    logic            unused_type_msb;

    // The upper opcode bit aliases onto the 0xx encodings.
    assign req_mode        = mult_type_e'(mult_type[1:0]);
    assign unused_type_msb = mult_type[2];

    assign accept = valid & ~flush & (state != CALC);

    // Signed ops are computed on magnitudes and the sign fixed up in FIN.
    assign req_a_sign = a[XLEN-1] & ((req_mode == MULH) | (req_mode == MULHSU));
    assign req_b_sign = b[XLEN-1] & (req_mode == MULH);
    assign req_mag_a  = req_a_sign ? (~a) + XLEN'(1) : a;
    assign req_mag_b  = req_b_sign ? (~b) + XLEN'(1) : b;

    // The op that is sitting in FIN is about to be committed to the cache,
    // so it is already visible to a back-to-back lookup in that cycle.
    assign cache_avail = cache_valid | ((state == FIN) & ~is_hit_q & (key_mode != MUL));

    // The low word of the product does not depend on signedness, so MUL may
    // reuse any full entry; MULH* must match the mode exactly.
    assign hit = REUSE_EN & cache_avail & (a == key_a) & (b == key_b)
               & ((req_mode == MUL) | (req_mode == key_mode));

    // Digit selection and shifting of the current partial product.
    assign a_shift    = op_a >> (PW * int'(dig_i));
    assign b_shift    = op_b >> (PW * int'(dig_j));
    assign a_dig      = a_shift[PW-1:0];
    assign b_dig      = b_shift[PW-1:0];
    assign pp_shifted = ACCW'(pp) << (PW * (int'(dig_i) + int'(dig_j)));

    xrv_mult_dsp #(.PW(PW)) u_dsp (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    assign last_pair  = (int'(pair_cnt) == (((cur_mode == MUL) ? P_MUL : P_FULL) - 1));
    assign end_of_row = (cur_mode == MUL) ? ((int'(dig_i) + int'(dig_j)) == (N - 1))
                                          : (int'(dig_j) == (N - 1));

    // neg_q is cleared for cache hits because the cached accumulator already
    // holds the signed product.
    assign acc_fin  = neg_q ? (~acc) + ACCW'(1) : acc;
    assign fin_word = (cur_mode == MUL) ? acc_fin[XLEN-1:0] : acc_fin[ACCW-1:XLEN];

    // In FIN the freshly finished word is shown directly so result and
    // result_valid line up; result_q keeps it stable afterwards.
    assign result = (state == FIN) ? fin_word : result_q;

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; flush overrides everything.
    always_comb begin
        next_state   = state;
        ready        = 1'b1;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = hit ? FIN : CALC;
            end
            CALC: begin
                ready = 1'b0;
                if (last_pair) next_state = FIN;
            end
            FIN: begin
                result_valid = 1'b1;
                if (accept) next_state = hit ? FIN : CALC;
                else        next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Datapath: digit counters, accumulator, result word and cache. Later
    // assignments in this block deliberately override earlier ones (a new
    // accept over the FIN commit, flush over everything for the cache).
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc         <= '0;
            result_q    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            key_a       <= '0;
            key_b       <= '0;
            key_mode    <= MUL;
            cur_mode    <= MUL;
            neg_q       <= 1'b0;
            is_hit_q    <= 1'b0;
            cache_valid <= 1'b0;
            dig_i       <= '0;
            dig_j       <= '0;
            pair_cnt    <= '0;
        end else begin
            if ((state == CALC) && !flush) begin
                acc      <= acc + pp_shifted;
                pair_cnt <= pair_cnt + 1'b1;
                if (end_of_row) begin
                    dig_i <= dig_i + 1'b1;
                    dig_j <= '0;
                end else begin
                    dig_j <= dig_j + 1'b1;
                end
            end

            if (state == FIN) begin
                result_q <= fin_word;
                acc      <= acc_fin;
                if (!is_hit_q) cache_valid <= (key_mode != MUL);
            end

            if (accept) begin
                cur_mode <= req_mode;
                is_hit_q <= hit;
                dig_i    <= '0;
                dig_j    <= '0;
                pair_cnt <= '0;
                if (hit) begin
                    neg_q <= 1'b0;
                end else begin
                    acc         <= '0;
                    op_a        <= req_mag_a;
                    op_b        <= req_mag_b;
                    neg_q       <= req_a_sign ^ req_b_sign;
                    key_a       <= a;
                    key_b       <= b;
                    key_mode    <= req_mode;
                    cache_valid <= 1'b0;
                end
            end

            if (flush) cache_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xrv_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_xrv_mult_seq
// Self-checking bench for xrv_mult_seq. Three instances share clock, reset,
// operands and flush: (XLEN=32,PW=16), (XLEN=32,PW=32) and (XLEN=64,PW=8).
// Expected products come from signed/unsigned wide arithmetic, expected
// latency from the pair count, and cache hits from a key/mode model.
// ---------------------------------------------------------------------------
module tb_xrv_mult_seq;

    logic        clk   = 1'b0;
    logic        rstb  = 1'b0;
    logic [63:0] a     = '0;
    logic [63:0] b     = '0;
    logic [2:0]  mt    = '0;
    logic        flush = 1'b0;
    logic        vld [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic [63:0] res [3];

    int total = 0;
    int bad   = 0;

    // Model of the reuse cache: one entry per instance.
    logic        mc_valid [3];
    logic [63:0] mc_a     [3];
    logic [63:0] mc_b     [3];
    logic [1:0]  mc_mode  [3];

    always #5 clk = ~clk;

    assign res[0] = {32'h0, res0};
    assign res[1] = {32'h0, res1};
    assign res[2] = res2;

    xrv_mult_seq #(.XLEN(32), .PW(16), .REUSE_EN(1'b1)) dut0 (
        .clk(clk), .rstb(rstb), .a(a[31:0]), .b(b[31:0]), .mult_type(mt),
        .valid(vld[0]), .flush(flush), .ready(rdy[0]), .result(res0),
        .result_valid(rv[0])
    );

    xrv_mult_seq #(.XLEN(32), .PW(32), .REUSE_EN(1'b1)) dut1 (
        .clk(clk), .rstb(rstb), .a(a[31:0]), .b(b[31:0]), .mult_type(mt),
        .valid(vld[1]), .flush(flush), .ready(rdy[1]), .result(res1),
        .result_valid(rv[1])
    );

    xrv_mult_seq #(.XLEN(64), .PW(8), .REUSE_EN(1'b1)) dut2 (
        .clk(clk), .rstb(rstb), .a(a), .b(b), .mult_type(mt),
        .valid(vld[2]), .flush(flush), .ready(rdy[2]), .result(res2),
        .result_valid(rv[2])
    );

    function automatic int xlen_of(input int d);
        return (d == 2) ? 64 : 32;
    endfunction

    function automatic int n_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Architectural result: sign-extend per the op, multiply wide, pick word.
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input logic [2:0] t, input int xlen);
        logic [129:0]        m;
        logic signed [129:0] ex, ey, p;
        logic [1:0]          k;
        k  = t[1:0];
        m  = (130'd1 << xlen) - 130'd1;
        ex = $signed(130'(x) & m);
        ey = $signed(130'(y) & m);
        if (((k == 2'd1) || (k == 2'd2)) && x[xlen-1]) ex = ex - $signed(130'd1 << xlen);
        if ((k == 2'd1) && y[xlen-1])                  ey = ey - $signed(130'd1 << xlen);
        p = ex * ey;
        if (k == 2'd0) return 64'(130'(p) & m);
        return 64'((130'(p) >> xlen) & m);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) mc_valid[d] = 1'b0;
    endtask

    // Issue one op to instance d (called at a negedge), wait for its pulse
    // and check both the word and the accept-to-pulse latency.
    task automatic applyStimulus(input int d, input logic [63:0] xi, input logic [63:0] yi,
                                 input logic [2:0] t, input string tag);
        logic [63:0] m, x, y, exp_r;
        logic [1:0]  k;
        logic        h;
        int          n, lat, exp_lat, guard;
        m = (xlen_of(d) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        x = xi & m;
        y = yi & m;
        k = t[1:0];
        n = n_of(d);
        h = mc_valid[d] && (mc_a[d] == x) && (mc_b[d] == y) && ((k == 2'd0) || (k == mc_mode[d]));
        if (h) begin
            exp_lat = 1;
        end else begin
            exp_lat     = ((k == 2'd0) ? (n * (n + 1)) / 2 : n * n) + 1;
            mc_valid[d] = (k != 2'd0);
            mc_a[d]     = x;
            mc_b[d]     = y;
            mc_mode[d]  = k;
        end
        exp_r = ref_mul(x, y, t, xlen_of(d));

        guard = 0;
        while (!rdy[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a      = x;
        b      = y;
        mt     = t;
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        lat    = 1;
        while (!rv[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_res"}, res[d], exp_r);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int          pulses;
        logic [63:0] rx, ry;
        logic [2:0]  rt;

        for (int d = 0; d < 3; d++) vld[d] = 1'b0;
        clear_model();

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rst_ready%0d", d), {63'b0, rdy[d]}, 64'd1);
            checkOutput($sformatf("rst_rv%0d", d),    {63'b0, rv[d]},  64'd0);
            checkOutput($sformatf("rst_res%0d", d),   res[d],          64'd0);
        end
        rstb = 1'b1;
        @(negedge clk);

        // Directed ops on the 32/16 instance
        applyStimulus(0, 64'h0001_0003, 64'h0002_0005, 3'b000, "mul_basic");
        applyStimulus(0, 64'h8000_0000, 64'h8000_0000, 3'b001, "mulh_minmin");
        applyStimulus(0, 64'hFFFF_FFFF, 64'h2,         3'b001, "mulh_neg1");
        applyStimulus(0, 64'hFFFF_FFFF, 64'h2,         3'b011, "mulhu_neg1");
        applyStimulus(0, 64'hFFFF_FFFF, 64'h2,         3'b010, "mulhsu_neg1");
        applyStimulus(0, 64'hFFFF_FFFF, 64'h2,         3'b110, "mulhsu_alias");

        // Reuse: MULH fills the cache, MUL hits, MULHU misses on mode
        applyStimulus(0, 64'h7, 64'hFFFF_FFFD, 3'b001, "reuse_mulh");
        applyStimulus(0, 64'h7, 64'hFFFF_FFFD, 3'b000, "reuse_mul_hit");
        applyStimulus(0, 64'h7, 64'hFFFF_FFFD, 3'b011, "reuse_mulhu_miss");

        // Back-to-back MULH misses accepted in FIN
        applyStimulus(0, 64'h1234_5678, 64'hDEAD_BEEF, 3'b001, "b2b_0");
        applyStimulus(0, 64'h8765_4321, 64'h0BAD_F00D, 3'b001, "b2b_1");
        applyStimulus(0, 64'h7FFF_FFFF, 64'h8000_0001, 3'b001, "b2b_2");

        // Flush in the second CALC cycle of a MULH
        a = 64'h0F0F_1234; b = 64'hF0F0_5678; mt = 3'b001;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
        checkOutput("flush_ready", {63'b0, rdy[0]}, 64'd1);
        checkOutput("flush_rv",    {63'b0, rv[0]},  64'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[0]) pulses++;
        end
        checkOutput("flush_quiet", 64'(pulses), 64'd0);
        applyStimulus(0, 64'h0F0F_1234, 64'hF0F0_5678, 3'b001, "flush_reissue");

        // Asynchronous reset in the middle of CALC
        a = 64'h5555_AAAA; b = 64'h3333_CCCC; mt = 3'b001;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checkOutput("midrst_ready", {63'b0, rdy[0]}, 64'd1);
        checkOutput("midrst_rv",    {63'b0, rv[0]},  64'd0);
        checkOutput("midrst_res",   res[0],          64'd0);
        @(negedge clk);
        rstb = 1'b1;
        clear_model();
        @(negedge clk);
        applyStimulus(0, 64'd3, 64'd5, 3'b000, "post_rst_mul");

        // Boundary operands on the other geometries
        applyStimulus(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b001, "pw32_mulh");
        applyStimulus(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b000, "pw32_mul_hit");
        applyStimulus(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, "x64_mulhsu");
        applyStimulus(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, "x64_mul");

        // Random sweep with occasional repeated operands to exercise the cache
        for (int d = 0; d < 3; d++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            for (int k = 0; k < 24; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    rx = {$urandom, $urandom};
                    ry = {$urandom, $urandom};
                    if ($urandom_range(0, 5) == 0) rx[63] = 1'b1;
                    if ($urandom_range(0, 5) == 0) ry[31] = 1'b1;
                end
                rt = 3'($urandom_range(0, 7));
                applyStimulus(d, rx, ry, rt, $sformatf("rnd_d%0d_%0d", d, k));
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xrv_mult_seq.md
# xrv_mult_seq

Parametrised sequential multiplier for the RV32/RV64 M-extension MUL, MULH, MULHSU and MULHU ops. It sits in the execute stage next to the ALU and is driven by the issue logic through a valid/ready handshake. A configurable-width partial-product unit is time-multiplexed to build the full 2·XLEN product. A one-entry operand cache returns fused MULH*/MUL pairs in one cycle, and a flush input kills in-flight work.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- PW, 16: partial-product digit width; must divide XLEN; N = XLEN/PW.
- REUSE_EN, 1: enables the operand-reuse cache.
- clk  in  1  clock, all logic on rising edge.
- rstb  in  1  asynchronous, active-low reset.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- mult_type  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx decoded as 0xx.
- valid  in  1  request; accepted on an edge where valid & ready & ~flush.
- flush  in  1  synchronous kill of the current op; also invalidates the cache.
- ready  out  1  block can accept a request this cycle.
- result  out  XLEN  product word; held stable until the next result_valid.
- result_valid  out  1  one-cycle pulse when result is new.

## Operation
- States:
  - IDLE: ready=1.
  - CALC: ready=0.
  - FIN: ready=1, result_valid=1.
- On accept, capture the following, then go to CALC, or to FIN on a cache hit:
  - a_sign = a[XLEN-1] & (type is MULH or MULHSU).
  - b_sign = b[XLEN-1] & (type is MULH).
  - Magnitudes |a| and |b| under those signs; MUL uses raw operands, signs forced to 0.
- CALC:
  - Each cycle, one PW×PW unsigned product of digits (i,j) is added into the 2·XLEN accumulator, shifted by (i+j)·PW.
  - Digit pairs are visited in lexicographic (i,j) order.
  - MUL skips pairs with i+j ≥ N, giving P = N(N+1)/2 pairs; the other types do all P = N² pairs.
  - The accumulator is cleared on accept.
- FIN:
  - If a_sign ^ b_sign, the accumulator is two's-complement negated (2·XLEN wide).
  - MUL registers the low word into result; the other types register the high word.
  - If valid & ~flush in FIN, the next op is accepted in the same cycle, so back-to-back ops have no bubble.
- Reuse cache:
  - Holds {a, b, mode, full}, stored on FIN.
  - full = 1 only for MULH* ops, where all N² pairs were done.
  - MUL hits on equal a,b with full=1 in any mode, since the low word is mode-independent.
  - MULH* hits only on equal a,b, equal mode and full=1.
  - On a hit the op goes straight to FIN. The stored signed/negated 2·XLEN product is kept in the accumulator.
  - A CALC accept overwrites the cache key; the cache is valid again only after FIN.
- flush:
  - Any state goes to IDLE next cycle; the cache is invalidated.
  - No result_valid is produced for a killed op.
  - flush with valid in the same cycle: flush wins and the request is not accepted.

## Timing
- Reset values:
  - state IDLE, ready=1, result_valid=0, result=0.
  - Accumulator 0, cache invalid.
- Reset mid-CALC aborts with no pulse.
- Latency is measured from the accept edge to the cycle result_valid is high:
  - Miss: P+1 cycles. With XLEN=32, PW=16: MUL 4, MULH* 5.
  - PW=XLEN: every type 2.
  - Hit: 1 cycle.
- Throughput for back-to-back misses: one result per P+1 cycles.
- result_valid is never high for two consecutive cycles except on consecutive cache hits.

## Structure
- Package xrv_mult_pkg holds:
  - The mult_type enum (MUL, MULH, MULHSU, MULHU).
  - The state enum (IDLE, CALC, FIN).
  - A helper function for the pair count P(N, is_mul).
- Sub-module xrv_mult_dsp: combinational PW×PW unsigned multiplier. It is kept separate so that a vendor DSP primitive can be substituted.
- Top level holds the FSM, digit counters i/j, accumulator, sign/negate logic and cache.

## Test plan
- MUL a=0x0001_0003, b=0x0002_0005 (XLEN=32, PW=16) -> result=0x000B_000F, result_valid 4 cycles after accept.
- MULH a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000 at latency 5. MULH a=0xFFFF_FFFF, b=2 -> 0xFFFF_FFFF. MULHU same operands -> 0x0000_0001. MULHSU same operands -> 0xFFFF_FFFF.
- Reuse sequence, a=7, b=0xFFFF_FFFD:
  - MULH -> 0xFFFF_FFFF.
  - Then MUL -> 0xFFFF_FFEB at latency 1.
  - Then MULHU (mode miss) -> 0x0000_0006 at latency 5.
- Flush in the 2nd CALC cycle of a MULH -> no result_valid, ready=1 next cycle. Re-issuing identical operands takes the full latency of 5 (no hit).
- valid held high with three MULH misses -> accepted in consecutive FIN cycles, result_valid pulses every 5 cycles with correct values.
- rstb asserted mid-CALC -> outputs at reset values immediately. After release, a MUL 3×5 -> 15.
- Parameter sweep PW ∈ {8, 16, 32}, XLEN ∈ {32, 64}: random operands and types checked against a reference model, with latency = P+1.
